cache_invalidate_sequencer: RTL



---
 rtl/cache_invalidate_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/cache_invalidate_sequencer.sv
// Whole-cache invalidation sequencer for the L0 cache; owns the cache write
// port during a sweep and passes the write controller through otherwise.
module cache_invalidate_sequencer #(
   parameter int XLEN            = 32,
   parameter int CacheIndexWidth = 7,
   parameter int CacheTagWidth   = 7
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush_req,
   output logic                       o_flush_busy,
   output logic                       o_flush_done,
   output logic                       o_stall_request,
   output logic                       o_write_conflict,
   input  logic                       i_cw_write_enable,
   input  logic [XLEN/8-1:0]          i_cw_byte_write_enable,
   input  logic [CacheIndexWidth-1:0] i_cw_write_index,
   input  logic [XLEN-1:0]            i_cw_write_data,
   input  logic [CacheTagWidth-1:0]   i_cw_write_tag,
   input  logic [XLEN/8-1:0]          i_cw_write_valid,
   output logic                       o_cache_write_enable,
   output logic [XLEN/8-1:0]          o_cache_byte_write_enable,
   output logic [CacheIndexWidth-1:0] o_cache_write_index,
   output logic [XLEN-1:0]            o_cache_write_data,
   output logic [CacheTagWidth-1:0]   o_cache_write_tag,
   output logic [XLEN/8-1:0]          o_cache_write_valid
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWEEP, S_DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [CacheIndexWidth-1:0] r_sweep_index, w_sweep_index_nxt;
   logic                       r_pending, w_pending_nxt;
   logic                       w_last;
   logic                       w_req_pend;

   assign w_last = &r_sweep_index;
   // A request at index 0 is covered by the sweep just starting; later ones need another pass.
   assign w_req_pend = r_pending | (i_flush_req & (r_sweep_index != '0));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_SWEEP;
         r_sweep_index <= '0;
         r_pending     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_sweep_index <= w_sweep_index_nxt;
         r_pending     <= w_pending_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_sweep_index_nxt = r_sweep_index;
      w_pending_nxt     = r_pending;
      case (r_state)
         S_IDLE: if (i_flush_req) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (!i_cw_write_enable) begin
               w_state_nxt       = S_SWEEP;
               w_sweep_index_nxt = '0;
            end
         end
         S_SWEEP: begin
            w_sweep_index_nxt = r_sweep_index + 1'b1;
            if (w_last) begin
               if (w_req_pend) w_pending_nxt = 1'b0;
               else            w_state_nxt   = S_DONE;
            end else begin
               w_pending_nxt = w_req_pend;
            end
         end
         S_DONE:  w_state_nxt = i_flush_req ? S_DRAIN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_cache_write_enable      = i_cw_write_enable;
      o_cache_byte_write_enable = i_cw_byte_write_enable;
      o_cache_write_index       = i_cw_write_index;
      o_cache_write_data        = i_cw_write_data;
      o_cache_write_tag         = i_cw_write_tag;
      o_cache_write_valid       = i_cw_write_valid;
      o_flush_busy              = (r_state == S_DRAIN) || (r_state == S_SWEEP);
      o_flush_done              = (r_state == S_DONE);
      o_write_conflict          = 1'b0;
      if (r_state == S_SWEEP) begin
         o_cache_write_enable      = 1'b1;
         o_cache_byte_write_enable = '1;
         o_cache_write_index       = r_sweep_index;
         o_cache_write_data        = '0;
         o_cache_write_tag         = '0;
         o_cache_write_valid       = '0;
         o_write_conflict          = i_cw_write_enable;
      end
      if (i_rst) begin
         o_cache_write_enable = 1'b0;
         o_flush_done         = 1'b0;
         o_write_conflict     = 1'b0;
         o_flush_busy         = 1'b1;
      end
      o_stall_request = o_flush_busy;
   end

endmodule
